// File: rtl/ray_dispatcher.sv
// Ray dispatcher: hands caster rays round-robin to a bank of tracer cores,
// captures their results per slot and returns them round-robin on one pixel port.
module ray_dispatcher #(
  parameter int NUM_TRACERS = 4,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 720
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [71:0]               in_origin,
  input  logic [71:0]               in_dir,
  input  logic [10:0]               in_h,
  input  logic [9:0]                in_v,
  output logic [NUM_TRACERS-1:0]    trc_start,
  output logic [71:0]               trc_origin,
  output logic [71:0]               trc_dir,
  output logic [10:0]               trc_h,
  output logic [9:0]                trc_v,
  input  logic [NUM_TRACERS-1:0]    trc_done,
  input  logic [NUM_TRACERS*72-1:0] trc_color,
  input  logic [NUM_TRACERS*11-1:0] trc_h_out,
  input  logic [NUM_TRACERS*10-1:0] trc_v_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [71:0]               out_color,
  output logic [10:0]               out_h,
  output logic [9:0]                out_v,
  output logic                      frame_done,
  output logic                      proto_err,
  output logic [2*NUM_TRACERS-1:0]  dbg_slot_state
);

  localparam int N    = NUM_TRACERS;
  localparam int PW   = (N > 1) ? $clog2(N) : 1;
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  // Handshake rule for both ports: a transfer happens on a rising clk edge
  // where valid and ready are both high; valid never depends on ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } slot_state_e;

  slot_state_e     r_state     [N];
  slot_state_e     w_state_nxt [N];
  logic [71:0]     r_color     [N];
  logic [10:0]     r_h         [N];
  logic [9:0]      r_v         [N];

  logic [PW-1:0]   r_disp_ptr, w_disp_ptr_nxt;
  logic [PW-1:0]   r_out_ptr, w_out_ptr_nxt;
  logic [PW-1:0]   r_hold_sel, w_hold_sel_nxt;
  logic            r_hold, w_hold_nxt;
  logic [PW-1:0]   w_disp_pick, w_rr_sel, w_sel;
  logic            w_disp_found, w_any_done, w_disp_fire, w_out_fire;
  logic            r_proto_err, w_proto_nxt;
  logic [N-1:0]    r_trc_start, w_start_nxt;
  logic [71:0]     r_trc_origin, r_trc_dir;
  logic [10:0]     r_trc_h;
  logic [9:0]      r_trc_v;
  logic [CW-1:0]   r_pix_cnt;
  logic            r_frame_done;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(N - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin scans: first IDLE from the dispatch pointer, first DONE from the output pointer.
  always_comb begin : scan
    int idx;
    logic [PW-1:0] sidx;
    w_disp_found = 1'b0;
    w_disp_pick  = '0;
    w_any_done   = 1'b0;
    w_rr_sel     = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(r_disp_ptr) + i;
      if (idx >= N) idx = idx - N;
      sidx = PW'(idx);
      if (!w_disp_found && r_state[sidx] == S_IDLE) begin
        w_disp_found = 1'b1;
        w_disp_pick  = sidx;
      end
      idx = int'(r_out_ptr) + i;
      if (idx >= N) idx = idx - N;
      sidx = PW'(idx);
      if (!w_any_done && r_state[sidx] == S_DONE) begin
        w_any_done = 1'b1;
        w_rr_sel   = sidx;
      end
    end
  end

  // A stalled pixel stays locked so a newer result cannot overtake it mid-offer.
  assign w_sel       = r_hold ? r_hold_sel : w_rr_sel;
  assign in_ready    = !rst && w_disp_found;
  assign w_disp_fire = in_valid && in_ready;
  assign out_valid   = w_any_done;
  assign w_out_fire  = w_any_done && out_ready;
  assign out_color   = r_color[w_sel];
  assign out_h       = r_h[w_sel];
  assign out_v       = r_v[w_sel];

  always_comb begin : next_state
    w_state_nxt    = r_state;
    w_disp_ptr_nxt = r_disp_ptr;
    w_out_ptr_nxt  = r_out_ptr;
    w_hold_nxt     = w_any_done && !out_ready;
    w_hold_sel_nxt = w_sel;
    w_proto_nxt    = r_proto_err;
    w_start_nxt    = '0;
    for (int k = 0; k < N; k++) begin
      if (trc_done[k]) begin
        if (r_state[k] == S_BUSY) w_state_nxt[k] = S_DONE;
        else                      w_proto_nxt    = 1'b1;
      end
      w_start_nxt[k] = w_disp_fire && (w_disp_pick == PW'(k));
    end
    // Picked slot is IDLE and selected slot is DONE, so these never collide with completions.
    if (w_disp_fire) begin
      w_state_nxt[w_disp_pick] = S_BUSY;
      w_disp_ptr_nxt           = next_ptr(w_disp_pick);
    end
    if (w_out_fire) begin
      w_state_nxt[w_sel] = S_IDLE;
      w_out_ptr_nxt      = next_ptr(w_sel);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_state[k] <= S_IDLE;
        r_color[k] <= '0;
        r_h[k]     <= '0;
        r_v[k]     <= '0;
      end
      r_disp_ptr   <= '0;
      r_out_ptr    <= '0;
      r_hold       <= 1'b0;
      r_hold_sel   <= '0;
      r_proto_err  <= 1'b0;
      r_trc_start  <= '0;
      r_trc_origin <= '0;
      r_trc_dir    <= '0;
      r_trc_h      <= '0;
      r_trc_v      <= '0;
      r_pix_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_disp_ptr  <= w_disp_ptr_nxt;
      r_out_ptr   <= w_out_ptr_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_sel  <= w_hold_sel_nxt;
      r_proto_err <= w_proto_nxt;
      r_trc_start <= w_start_nxt;
      for (int k = 0; k < N; k++) begin
        if (trc_done[k] && r_state[k] == S_BUSY) begin
          r_color[k] <= trc_color[72*k +: 72];
          r_h[k]     <= trc_h_out[11*k +: 11];
          r_v[k]     <= trc_v_out[10*k +: 10];
        end
      end
      if (w_disp_fire) begin
        r_trc_origin <= in_origin;
        r_trc_dir    <= in_dir;
        r_trc_h      <= in_h;
        r_trc_v      <= in_v;
      end
      r_frame_done <= 1'b0;
      if (w_out_fire) begin
        if (r_pix_cnt == CW'(NPIX - 1)) begin
          r_pix_cnt    <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_pix_cnt <= r_pix_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    dbg_slot_state = '0;
    for (int k = 0; k < N; k++) dbg_slot_state[2*k +: 2] = r_state[k];
  end

  assign trc_start  = r_trc_start;
  assign trc_origin = r_trc_origin;
  assign trc_dir    = r_trc_dir;
  assign trc_h      = r_trc_h;
  assign trc_v      = r_trc_v;
  assign frame_done = r_frame_done;
  assign proto_err  = r_proto_err;

endmodule
